// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multicycle restoring signed/unsigned divider with start/busy/done handshake
// Optional feature macro: DIV_UNSIGNED_EN (enables the is_unsigned DIVU bypass)
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_unsigned,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        ZERO = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mag_a_q, mag_a_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] q_acc_q, q_acc_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic             fix_pend_q, fix_pend_d;
    logic             zero_pend_q, zero_pend_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;

    logic             signed_op;
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;

`ifdef DIV_UNSIGNED_EN
    assign signed_op = ~is_unsigned;
`else
    logic unused_is_unsigned;
    assign unused_is_unsigned = is_unsigned;
    assign signed_op          = 1'b1;
`endif

    assign neg_a = signed_op & dividend[WIDTH-1];
    assign neg_b = signed_op & divisor[WIDTH-1];

    // Shift in the next dividend bit at full WIDTH+1 precision so the trial subtraction never loses a carry
    assign rem_shift = {rem_q, mag_a_q[cnt_q]};
    assign diff      = rem_shift - {1'b0, mag_b_q};

    // State and datapath registers; synchronous reset clears everything and cancels any pending done
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mag_a_q     <= '0;
            mag_b_q     <= '0;
            rem_q       <= '0;
            q_acc_q     <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            fix_pend_q  <= 1'b0;
            zero_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mag_a_q     <= mag_a_d;
            mag_b_q     <= mag_b_d;
            rem_q       <= rem_d;
            q_acc_q     <= q_acc_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            fix_pend_q  <= fix_pend_d;
            zero_pend_q <= zero_pend_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            div_zero_q  <= div_zero_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    // Next-state logic: start is only honoured in IDLE, a zero divisor short-circuits to ZERO
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (divisor == '0) ? ZERO : CALC;
                end
            end
            CALC: begin
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX:     state_d = IDLE;
            ZERO:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and outputs: one quotient bit per CALC cycle, sign fix-up in FIX, results published a cycle later
    always_comb begin
        cnt_d       = cnt_q;
        mag_a_d     = mag_a_q;
        mag_b_d     = mag_b_q;
        rem_d       = rem_q;
        q_acc_d     = q_acc_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mag_a_d    = neg_a ? -dividend : dividend;
                    mag_b_d    = neg_b ? -divisor : divisor;
                    sign_a_d   = neg_a;
                    sign_b_d   = neg_b;
                    rem_d      = '0;
                    q_acc_d    = '0;
                    cnt_d      = CW'(WIDTH - 1);
                    div_zero_d = 1'b0;
                end
            end
            CALC: begin
                if (!diff[WIDTH]) begin
                    rem_d          = diff[WIDTH-1:0];
                    q_acc_d[cnt_q] = 1'b1;
                end else begin
                    rem_d          = rem_shift[WIDTH-1:0];
                    q_acc_d[cnt_q] = 1'b0;
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                q_acc_d = (sign_a_q ^ sign_b_q) ? -q_acc_q : q_acc_q;
                rem_d   = sign_a_q ? -rem_q : rem_q;
            end
            ZERO: begin
                q_acc_d = '0;
                rem_d   = '0;
            end
            default: ;
        endcase

        fix_pend_d  = (state_q == FIX);
        zero_pend_d = (state_q == ZERO);
        busy_d      = (state_q != IDLE);
        done_d      = fix_pend_q | zero_pend_q;

        // Completion wins over a same-edge start so the finishing operation's flag is not lost
        if (fix_pend_q | zero_pend_q) begin
            quotient_d  = q_acc_q;
            remainder_d = rem_q;
        end
        if (zero_pend_q) begin
            div_zero_d = 1'b1;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider (table vectors, hand sequences, random vs model)
module tb_seq_divider;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic         is_unsigned;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    int checks   = 0;
    int failures = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .is_unsigned(is_unsigned),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_zero   (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           uns;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        bit           edz;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic (SV division truncates toward zero, % follows the dividend)
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit uns,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output bit dz);
        bit eff_uns;
        longint sa;
        longint sb;
`ifdef DIV_UNSIGNED_EN
        eff_uns = uns;
`else
        eff_uns = 1'b0;
        if (uns) eff_uns = 1'b0;
`endif
        if (b == '0) begin
            q = '0; r = '0; dz = 1'b1;
        end else if (eff_uns) begin
            q = a / b; r = a % b; dz = 1'b0;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = W'(sa / sb);
            r = W'(sa % sb);
            dz = 1'b0;
        end
    endfunction

    // One operation with handshake checks; intr >= 0 injects a start that must be ignored
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit uns, input int intr,
                          output logic [W-1:0] q, output logic [W-1:0] r, output bit dz);
        int lat;
        int bcnt;
        bit got;
        @(negedge clk);
        dividend    = a;
        divisor     = b;
        is_unsigned = uns;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("div_zero_cleared_on_start", {63'd0, div_zero}, 64'd0);
        lat  = 0;
        bcnt = 0;
        got  = 1'b0;
        while (!got && lat < 100) begin
            if (lat == intr) begin
                start    = 1'b1;
                dividend = ~a;
                divisor  = b + 32'd1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
            if (busy) bcnt++;
            if (done) begin
                got = 1'b1;
                check("busy_low_with_done", {63'd0, busy}, 64'd0);
            end
        end
        check("done_latency", 64'(lat), (b == '0) ? 64'd2 : 64'(W + 2));
        check("busy_cycles", 64'(bcnt), (b == '0) ? 64'd1 : 64'(W + 1));
        q  = quotient;
        r  = remainder;
        dz = div_zero;
        @(posedge clk);
        #1;
        check("done_single_cycle", {63'd0, done}, 64'd0);
        check("quotient_held", 64'(quotient), 64'(q));
    endtask

    initial begin
        logic [W-1:0] q, r, eq, er;
        bit           dz, edz;
        int           dones;

        tbl[0]  = '{32'd7,        32'd2,        1'b0, 32'd3,        32'd1,        1'b0};
        tbl[1]  = '{32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
        tbl[2]  = '{32'd7,        32'hFFFFFFFE, 1'b0, 32'hFFFFFFFD, 32'd1,        1'b0};
        tbl[3]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 32'd0,        1'b0};
        tbl[4]  = '{32'd5,        32'd0,        1'b0, 32'd0,        32'd0,        1'b1};
        tbl[5]  = '{32'd9,        32'd3,        1'b0, 32'd3,        32'd0,        1'b0};
`ifdef DIV_UNSIGNED_EN
        tbl[6]  = '{32'hFFFFFFFE, 32'd2,        1'b1, 32'h7FFFFFFF, 32'd0,        1'b0};
`else
        tbl[6]  = '{32'hFFFFFFFE, 32'd2,        1'b1, 32'hFFFFFFFF, 32'd0,        1'b0};
`endif
        tbl[7]  = '{32'hFFFFFFF8, 32'hFFFFFFFD, 1'b0, 32'd2,        32'hFFFFFFFE, 1'b0};
        tbl[8]  = '{32'd0,        32'd5,        1'b0, 32'd0,        32'd0,        1'b0};
        tbl[9]  = '{32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        1'b0};
        tbl[10] = '{32'h7FFFFFFF, 32'd1,        1'b0, 32'h7FFFFFFF, 32'd0,        1'b0};
        tbl[11] = '{32'h80000000, 32'd2,        1'b0, 32'hC0000000, 32'd0,        1'b0};

        reset       = 1'b1;
        start       = 1'b0;
        is_unsigned = 1'b0;
        dividend    = '0;
        divisor     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_div_zero", {63'd0, div_zero}, 64'd0);
        check("reset_quotient", 64'(quotient), 64'd0);
        check("reset_remainder", 64'(remainder), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].uns, -1, q, r, dz);
            check($sformatf("tbl%0d_quotient", i), 64'(q), 64'(tbl[i].eq));
            check($sformatf("tbl%0d_remainder", i), 64'(r), 64'(tbl[i].er));
            check($sformatf("tbl%0d_div_zero", i), {63'd0, dz}, {63'd0, tbl[i].edz});
            if (i == 4) check("div_zero_level_held", {63'd0, div_zero}, 64'd1);
        end

        // A start raised mid-operation must not disturb the result
        run_op(32'd100, 32'd7, 1'b0, 5, q, r, dz);
        check("busy_start_quotient", 64'(q), 64'd14);
        check("busy_start_remainder", 64'(r), 64'd2);

        // Reset ten cycles into an operation aborts it with no done pulse
        @(negedge clk);
        dividend = 32'd7;
        divisor  = 32'd2;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_quotient", 64'(quotient), 64'd0);
        check("abort_remainder", 64'(remainder), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);

        // Randomized operands against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] ra, rb;
            bit ru;
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = 32'($urandom_range(1, 15));
                3:       rb = -32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
            ru = 1'($urandom_range(0, 1));
            model(ra, rb, ru, eq, er, edz);
            run_op(ra, rb, ru, -1, q, r, dz);
            check($sformatf("rand%0d_quotient", i), 64'(q), 64'(eq));
            check($sformatf("rand%0d_remainder", i), 64'(r), 64'(er));
            check($sformatf("rand%0d_div_zero", i), {63'd0, dz}, {63'd0, edz});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
